attitude_pid: RTL and testbench
===============================

// Module: attitude_pid
// PURPOSE
//  Three-axis attitude PID stage directly downstream of the complementary filter.
//  Consumes filtered pitch/roll/yaw and target angles; produces saturated signed correction commands for the motor mixer.
//  Time-multiplexes one multiply-accumulate across the three axes, driven by a sequential FSM.
//  Runs once per filter update.
// PARAMETERS
//  KP       16'sd256    proportional gain, signed Q8.8 (256 = 1.0)
//  KI       16'sd0      integral gain, signed Q8.8
//  KD       16'sd0      derivative gain, signed Q8.8
//  I_LIM    24'sd1048576  integrator clamp magnitude; integrator kept in [-I_LIM, +I_LIM]
//  OUT_LIM  16'sd30000  output clamp magnitude; outputs kept in [-OUT_LIM, +OUT_LIM]
// PORTS
//  Clocking: one clock; reset is synchronous and active-high.
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  pid_en     in   1   start pulse; accepted only in IDLE
//  cur_pitch  in   24  filtered pitch, signed
//  cur_roll   in   24  filtered roll, signed
//  cur_yaw    in   24  filtered yaw rate, signed
//  tgt_pitch  in   24  pitch setpoint, signed
//  tgt_roll   in   24  roll setpoint, signed
//  tgt_yaw    in   24  yaw setpoint, signed
//  pitch_out  out  16  pitch command, signed, registered
//  roll_out   out  16  roll command, signed, registered
//  yaw_out    out  16  yaw command, signed, registered
//  busy       out  1   high from acceptance of pid_en through the DONE cycle
//  pid_done   out  1   one-cycle pulse; new outputs are valid in the same cycle
// BEHAVIOUR
//  Reset:
//  - Outputs, pid_done, busy, all integrators, e_prev and accumulator go to 0.
//  - FSM returns to IDLE. Reset takes priority over everything.
//  Reset mid-run: the run is abandoned, no pid_done is issued, and all state is cleared.
//  Start:
//  - pid_en in IDLE is accepted in cycle 0: all six inputs are snapshotted and axis <= PITCH.
//  - pid_en while busy is ignored; it is neither queued nor does it restart the run.
//  Per-axis states (1 cycle each), in axis order PITCH, ROLL, YAW:
//  - ERR: e = sat24(tgt - cur), computed 25-bit then clamped to +/-(2^23-1).
//  - P:   acc = KP*e (40-bit).
//  - I:   integ = clamp(integ + e, +/-I_LIM); acc += KI*integ_new.
//  - D:   d = sat24(e - e_prev); acc += KD*d; e_prev <= e.
//  - OUT: res[axis] = clamp(acc >>> 8, +/-OUT_LIM).
//         The shift is arithmetic, toward -inf. The acc is 42-bit signed, so it never overflows.
//         Then axis++, or go to DONE after YAW.
//  DONE:
//  - pitch_out/roll_out/yaw_out update together; pid_done=1 for one cycle; next state is IDLE.
//  - Outputs hold between runs.
//  Latency and throughput:
//  - Cycle 0 accept; cycles 1-15 axis work; pid_done in cycle 16.
//  - Next pid_en can be accepted in cycle 17. Minimum period 17 cycles.
//  Boundary conditions:
//  - First run after reset uses e_prev = 0, so the D term equals KD*e.
//  - Integrator clamp is applied before the multiply.
//  - Integrator wind-up is bounded; it is not cleared between runs.
//  - pid_en held high continuously restarts a run on every IDLE cycle.
// STRUCTURE
//  Package attitude_pkg:
//  - axis_t enum {PITCH, ROLL, YAW}
//  - pid_state_t enum {IDLE, ERR, P, I, D, OUT, DONE}
//  - Q_FRAC = 8 constant
//  - sat/clamp functions, shared with cmp_filter users
//  Sub-module pid_mac:
//  - One 16x24 signed multiplier plus 42-bit accumulator.
//  - Controls: clr (load) and acc (add).
//  - Shared across all axes and terms.
//  Top level holds the FSM, snapshot registers, the per-axis integ[3] and e_prev[3] arrays, and the output registers.
// TESTING
//  1. KP=256, KI=KD=0; tgt_pitch=100, cur_pitch=0, pulse pid_en
//     -> pid_done in cycle 16, pitch_out=100, roll_out=yaw_out=0.
//  2. KP=256; tgt_roll=0, cur_roll=-40000
//     -> roll_out=+30000 (OUT_LIM saturation); cur_roll=+40000 -> roll_out=-30000.
//  3. KI=256, KP=KD=0; err_yaw=10 for three runs
//     -> yaw_out 10, 20, 30.
//     With I_LIM=25: yaw_out 10, 20, 25, 25.
//  4. KD=256, KP=KI=0; err_pitch=50 on run 1 -> pitch_out=50.
//     Same error on run 2 -> pitch_out=0. Error -50 on run 3 -> pitch_out=-100.
//  5. Pulse pid_en again in cycle 5 of a run
//     -> ignored; exactly one pid_done, in cycle 16.
//  6. Assert rst in cycle 8 of a run
//     -> no pid_done; outputs and integrators read 0; a fresh run matches test 1 results.

Source files
------------

// File: rtl/attitude_pkg.sv
// attitude_pkg: shared axis/state types, fixed-point constant and saturation helpers
// for the attitude control path.
package attitude_pkg;

    typedef enum logic [1:0] {PITCH, ROLL, YAW} axis_t;
    typedef enum logic [2:0] {IDLE, ERR, P, I, D, OUT, DONE} pid_state_t;

    localparam int Q_FRAC = 8;
    localparam logic signed [23:0] E_MAX = 24'sh7fffff;

    function automatic logic signed [23:0] clamp24(input logic signed [41:0] v, input logic signed [23:0] lim);
        return v > 42'(lim) ? lim : v < -42'(lim) ? -lim : v[23:0];
    endfunction

    function automatic logic signed [15:0] clamp16(input logic signed [41:0] v, input logic signed [15:0] lim);
        return v > 42'(lim) ? lim : v < -42'(lim) ? -lim : v[15:0];
    endfunction

    // Symmetric saturation keeps -2^23 out so negating an error never overflows.
    function automatic logic signed [23:0] sat24(input logic signed [41:0] v);
        return clamp24(v, E_MAX);
    endfunction

endpackage

// File: rtl/attitude_pid_mac.sv
// pid_mac: one 16x24 signed multiplier feeding a 42-bit accumulator, shared by
// every axis and every P/I/D term.
module pid_mac
    import attitude_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                acc_i,
    input  logic signed [15:0]  coef_i,
    input  logic signed [23:0]  op_i,
    output logic signed [41:0]  acc_o
);

    logic signed [39:0] prod;
    logic signed [41:0] acc_q, acc_d;

    assign prod = 40'(coef_i) * 40'(op_i);

    always_comb begin
        acc_d = clr_i ? 42'(prod) : acc_i ? acc_q + 42'(prod) : acc_q;
    end

    always_ff @(posedge clk) begin
        acc_q <= rst ? '0 : acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/attitude_pid.sv
// attitude_pid: three-axis PID stage; one FSM walks ERR/P/I/D/OUT per axis over a
// shared MAC and publishes all three saturated commands together with pid_done.
module attitude_pid
    import attitude_pkg::*;
#(
    parameter logic signed [15:0] KP      = 16'sd256,
    parameter logic signed [15:0] KI      = 16'sd0,
    parameter logic signed [15:0] KD      = 16'sd0,
    parameter logic signed [23:0] I_LIM   = 24'sd1048576,
    parameter logic signed [15:0] OUT_LIM = 16'sd30000
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                pid_en,
    input  logic signed [23:0]  cur_pitch,
    input  logic signed [23:0]  cur_roll,
    input  logic signed [23:0]  cur_yaw,
    input  logic signed [23:0]  tgt_pitch,
    input  logic signed [23:0]  tgt_roll,
    input  logic signed [23:0]  tgt_yaw,
    output logic signed [15:0]  pitch_out,
    output logic signed [15:0]  roll_out,
    output logic signed [15:0]  yaw_out,
    output logic                busy,
    output logic                pid_done
);

    pid_state_t state_q, state_d;
    axis_t axis_q, axis_d;
    logic signed [23:0] cur_q [3];
    logic signed [23:0] tgt_q [3];
    logic signed [23:0] integ_q [3];
    logic signed [23:0] e_prev_q [3];
    logic signed [15:0] res_q [3];
    logic signed [23:0] e_q, e_d, integ_new, d_val, mac_op;
    logic signed [15:0] pitch_q, roll_q, yaw_q, res_new, mac_coef;
    logic signed [41:0] mac_acc;

    always_comb begin
        state_d = state_q;
        axis_d = axis_q;
        case (state_q)
            IDLE: begin
                state_d = pid_en ? ERR : IDLE;
                axis_d = pid_en ? PITCH : axis_q;
            end
            ERR: state_d = P;
            P: state_d = I;
            I: state_d = D;
            D: state_d = OUT;
            OUT: begin
                state_d = axis_q == YAW ? DONE : ERR;
                axis_d = axis_q == YAW ? axis_q : axis_t'(axis_q + 2'd1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign e_d = sat24(42'(tgt_q[axis_q]) - 42'(cur_q[axis_q]));
    assign integ_new = clamp24(42'(integ_q[axis_q]) + 42'(e_q), I_LIM);
    assign d_val = sat24(42'(e_q) - 42'(e_prev_q[axis_q]));
    assign res_new = clamp16(mac_acc >>> Q_FRAC, OUT_LIM);

    always_comb begin
        mac_coef = state_q == P ? KP : state_q == I ? KI : KD;
        mac_op = state_q == P ? e_q : state_q == I ? integ_new : d_val;
    end

    pid_mac u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == P),
        .acc_i  (state_q == I || state_q == D),
        .coef_i (mac_coef),
        .op_i   (mac_op),
        .acc_o  (mac_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            axis_q <= PITCH;
            e_q <= '0;
            pitch_q <= '0;
            roll_q <= '0;
            yaw_q <= '0;
            for (int k = 0; k < 3; k++) begin
                cur_q[k] <= '0;
                tgt_q[k] <= '0;
                integ_q[k] <= '0;
                e_prev_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            axis_q <= axis_d;
            if (state_q == IDLE && pid_en) begin
                cur_q[PITCH] <= cur_pitch;
                cur_q[ROLL] <= cur_roll;
                cur_q[YAW] <= cur_yaw;
                tgt_q[PITCH] <= tgt_pitch;
                tgt_q[ROLL] <= tgt_roll;
                tgt_q[YAW] <= tgt_yaw;
            end
            if (state_q == ERR) e_q <= e_d;
            if (state_q == I) integ_q[axis_q] <= integ_new;
            if (state_q == D) e_prev_q[axis_q] <= e_q;
            if (state_q == OUT) res_q[axis_q] <= res_new;
            // Commit all three axes on the same edge so they appear together with pid_done.
            if (state_q == OUT && axis_q == YAW) begin
                pitch_q <= res_q[PITCH];
                roll_q <= res_q[ROLL];
                yaw_q <= res_new;
            end
        end
    end

    assign pitch_out = pitch_q;
    assign roll_out = roll_q;
    assign yaw_out = yaw_q;
    assign busy = state_q != IDLE;
    assign pid_done = state_q == DONE;

endmodule

// File: tb/tb_attitude_pid.sv
// tb_attitude_pid: four gain configurations driven in lockstep; a scoreboard queue of
// hand-computed results is drained by a monitor on every pid_done.
module tb_attitude_pid;

    typedef struct packed {
        int               start;
        logic [3:0]       chk;
        logic [11:0][15:0] ex;
    } exp_t;

    logic clk = 0, rst = 1, pid_en = 0;
    logic signed [23:0] cur_p = 0, cur_r = 0, cur_y = 0, tgt_p = 0, tgt_r = 0, tgt_y = 0;
    logic signed [15:0] po [4];
    logic signed [15:0] ro [4];
    logic signed [15:0] yo [4];
    logic dn [4];
    logic bz [4];
    int cyc = 0, total = 0, bad = 0;
    exp_t q[$];
    logic [11:0][15:0] exp_v;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u_p: P only, u_i: I only, u_il: I only with tight clamp, u_d: D only
    attitude_pid u_p (.clk(clk), .rst(rst), .pid_en(pid_en),
        .cur_pitch(cur_p), .cur_roll(cur_r), .cur_yaw(cur_y), .tgt_pitch(tgt_p), .tgt_roll(tgt_r), .tgt_yaw(tgt_y),
        .pitch_out(po[0]), .roll_out(ro[0]), .yaw_out(yo[0]), .busy(bz[0]), .pid_done(dn[0]));
    attitude_pid #(.KP(16'sd0), .KI(16'sd256)) u_i (.clk(clk), .rst(rst), .pid_en(pid_en),
        .cur_pitch(cur_p), .cur_roll(cur_r), .cur_yaw(cur_y), .tgt_pitch(tgt_p), .tgt_roll(tgt_r), .tgt_yaw(tgt_y),
        .pitch_out(po[1]), .roll_out(ro[1]), .yaw_out(yo[1]), .busy(bz[1]), .pid_done(dn[1]));
    attitude_pid #(.KP(16'sd0), .KI(16'sd256), .I_LIM(24'sd25)) u_il (.clk(clk), .rst(rst), .pid_en(pid_en),
        .cur_pitch(cur_p), .cur_roll(cur_r), .cur_yaw(cur_y), .tgt_pitch(tgt_p), .tgt_roll(tgt_r), .tgt_yaw(tgt_y),
        .pitch_out(po[2]), .roll_out(ro[2]), .yaw_out(yo[2]), .busy(bz[2]), .pid_done(dn[2]));
    attitude_pid #(.KP(16'sd0), .KD(16'sd256)) u_d (.clk(clk), .rst(rst), .pid_en(pid_en),
        .cur_pitch(cur_p), .cur_roll(cur_r), .cur_yaw(cur_y), .tgt_pitch(tgt_p), .tgt_roll(tgt_r), .tgt_yaw(tgt_y),
        .pitch_out(po[3]), .roll_out(ro[3]), .yaw_out(yo[3]), .busy(bz[3]), .pid_done(dn[3]));

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (dn[0]) begin
            if (q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("latency", cyc - e.start, 16);
                for (int i = 0; i < 4; i++) begin
                    if (e.chk[i]) begin
                        check($sformatf("pitch%0d", i), po[i], $signed(e.ex[i*3]));
                        check($sformatf("roll%0d", i), ro[i], $signed(e.ex[i*3+1]));
                        check($sformatf("yaw%0d", i), yo[i], $signed(e.ex[i*3+2]));
                        check($sformatf("done%0d", i), int'(dn[i]), 1);
                    end
                end
            end
        end
    end

    task automatic setx(input int i, input int p, input int r, input int y);
        exp_v[i*3] = 16'(p);
        exp_v[i*3+1] = 16'(r);
        exp_v[i*3+2] = 16'(y);
    endtask

    task automatic run(input logic [3:0] c, input bit extra);
        exp_t e;
        e.start = cyc;
        e.chk = c;
        e.ex = exp_v;
        q.push_back(e);
        pid_en = 1;
        @(negedge clk) pid_en = 0;
        if (extra) begin
            repeat (4) @(negedge clk);
            check("busy_mid", int'(bz[0]), 1);
            pid_en = 1;
            @(negedge clk) pid_en = 0;
            repeat (13) @(negedge clk);
        end else repeat (17) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        exp_v = '0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("rst_pitch", po[i], 0);
            check("rst_roll", ro[i], 0);
            check("rst_yaw", yo[i], 0);
            check("rst_done", int'(dn[i]), 0);
        end
        check("rst_busy", int'(bz[0]), 0);
        tgt_p = 100;
        setx(0, 100, 0, 0);
        run(4'b0001, 0);
        cur_r = -40000;
        setx(0, 100, 30000, 0);
        run(4'b0001, 0);
        cur_r = 40000;
        setx(0, 100, -30000, 0);
        run(4'b0001, 0);
        run(4'b0001, 1);
        do_reset();
        tgt_p = 0;
        cur_r = 0;
        tgt_y = 10;
        setx(1, 0, 0, 10); setx(2, 0, 0, 10); setx(3, 0, 0, 10);
        run(4'b1110, 0);
        setx(1, 0, 0, 20); setx(2, 0, 0, 20); setx(3, 0, 0, 0);
        run(4'b1110, 0);
        setx(1, 0, 0, 30); setx(2, 0, 0, 25);
        run(4'b0110, 0);
        setx(1, 0, 0, 40);
        run(4'b0110, 0);
        do_reset();
        tgt_y = 0;
        tgt_p = 50;
        setx(0, 50, 0, 0); setx(3, 50, 0, 0);
        run(4'b1001, 0);
        setx(3, 0, 0, 0);
        run(4'b1001, 0);
        tgt_p = -50;
        setx(0, -50, 0, 0); setx(3, -100, 0, 0);
        run(4'b1001, 0);
        tgt_p = 100;
        pid_en = 1;
        @(negedge clk) pid_en = 0;
        repeat (7) @(negedge clk);
        rst = 1;
        @(negedge clk) rst = 0;
        for (int i = 0; i < 4; i++) begin
            check("abort_pitch", po[i], 0);
            check("abort_roll", ro[i], 0);
            check("abort_yaw", yo[i], 0);
        end
        check("abort_busy", int'(bz[0]), 0);
        setx(0, 100, 0, 0); setx(1, 100, 0, 0); setx(3, 100, 0, 0);
        run(4'b1011, 0);
        repeat (5) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
